alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 req0_op, req1_op  input  4 each  ALU control code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT).
REQ-007 req0_a, req0_b, req1_a, req1_b  input  DATA_W each  operands.
REQ-008 alu_var1, alu_var2  output  DATA_W each  ALU operand drive.
REQ-009 alu_control  output  4  ALU operation drive.
REQ-010 alu_out  input  DATA_W; alu_zero  input  1  combinational ALU result and zero flag.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-012 rsp_id  output  1  requester index of the response.
REQ-013 rsp_result  output  DATA_W; rsp_zero  output  1; rsp_err  output  1  response payload.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; IDLE->EXEC on any accept; EXEC->RESP unconditionally; RESP->IDLE when rsp_ready is high.
REQ-015 reqN_ready shall be high only in IDLE, for the granted requester only, combinationally from the valids and the priority pointer.
REQ-016 Accept = reqN_valid && reqN_ready; on accept, op, a, b and the requester index shall be latched.
REQ-017 Arbitration: one valid -> that one granted; both valid -> requester not granted last; pointer updates only on accept.
REQ-018 In EXEC, alu_var1/alu_var2/alu_control shall be driven from the latched values; alu_out/alu_zero captured into response registers at the end of EXEC.
REQ-019 Outside EXEC, alu_var1/alu_var2 shall be 0 and alu_control 4'b0000.
REQ-020 Latency: accept in cycle N -> rsp_valid high in cycle N+2; max throughput one operation per 3 cycles.
REQ-021 In RESP, rsp_valid high and payload held stable until rsp_ready; no new accept in the cycle rsp_ready is seen.
REQ-022 Requester valids dropped without acceptance shall have no effect; no requests are queued.

Reset
REQ-023 Reset: state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_err 0, pointer set so requester 0 wins the first tie.
REQ-024 Reset asserted in EXEC or RESP shall abandon the operation; no response is produced for it.

Configuration
REQ-025 Macro ALU_ARBITER_OPCHECK_EN defined: an op outside the five legal codes shall still execute but set rsp_err=1 with its response.
REQ-026 Macro undefined: rsp_err shall be constant 0 and no opcode decode logic present.

Structure
REQ-027 Package alu_arbiter_pkg shall hold the FSM state type and the five ALU control code constants.
REQ-028 Sub-module rr_arb2 shall implement the two-way round-robin grant and pointer.

Verification
REQ-029 Single req0 ADD 100,50, rsp_ready=1 -> rsp_valid at accept+2, rsp_id=0, rsp_result=150, rsp_zero=0.
REQ-030 req0 and req1 both valid continuously (SUB 100,100 / OR 0x0000FFFF,0xFFFF0000) -> responses alternate id 0,1,0,...; first id 0 shows result 0 with zero=1, id 1 shows 0xFFFFFFFF.
REQ-031 req1 SLT 10,20 with rsp_ready low 5 cycles -> rsp_valid and result 1 held stable 5 cycles, both readies low throughout.
REQ-032 Reset pulsed during EXEC of req0 AND 0xFF00FF00,0x0F0F0F0F -> no rsp_valid; next request handled normally with id 0 priority.
REQ-033 With ALU_ARBITER_OPCHECK_EN, req0 op 1111 on 123,456 -> rsp_err=1; without the macro -> rsp_err=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: FSM state type, the five ALU control codes and an opcode legality helper shared by alu_arbiter and its bench
package alu_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  function automatic logic op_legal(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bus of alu_arbiter (two requesters with valid/ready/op/a/b, ALU drive var1/var2/control and result alu_out/alu_zero, response valid/ready/id/result/zero/err); slave = arbiter, master = environment
interface alu_arbiter_if #(parameter int DATA_W = 32);
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]        req0_op, req1_op, alu_control;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DATA_W-1:0] alu_var1, alu_var2, alu_out, rsp_result;
  logic              alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
           alu_out, alu_zero, rsp_ready,
    output req0_ready, req1_ready, alu_var1, alu_var2, alu_control,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
           alu_out, alu_zero, rsp_ready,
    input  req0_ready, req1_ready, alu_var1, alu_var2, alu_control,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant (ports clk, reset, en, valid[1:0] in; grant[1:0] out); a tie goes to the requester not granted last, the pointer moves only when a grant is issued
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last;
  assign grant = !en ? 2'b00 : (valid == 2'b11) ? (last ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= 1'b1;
    else if (|grant) last <= grant[1];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters (ports clk, reset, bus: alu_arbiter_if.slave); IDLE->EXEC->RESP per operation, optional illegal-opcode flag under ALU_ARBITER_OPCHECK_EN
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  state_t            state, state_n;
  logic [1:0]        grant;
  logic              accept, id_q, zero_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state == IDLE),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );
  assign accept         = |grant;
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  always_comb begin
    state_n         = state;
    bus.alu_var1    = '0;
    bus.alu_var2    = '0;
    bus.alu_control = OP_AND;
    bus.rsp_valid   = 1'b0;
    if (state == IDLE && accept) state_n = EXEC;
    if (state == EXEC) state_n = RESP;
    if (state == RESP && bus.rsp_ready) state_n = IDLE;
    if (state == EXEC) begin
      bus.alu_var1    = a_q;
      bus.alu_var2    = b_q;
      bus.alu_control = op_q;
    end
    bus.rsp_valid = state == RESP;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q   <= OP_AND;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= grant[1] ? bus.req1_op : bus.req0_op;
        a_q  <= grant[1] ? bus.req1_a : bus.req0_a;
        b_q  <= grant[1] ? bus.req1_b : bus.req0_b;
        id_q <= grant[1];
      end
      if (state == EXEC) begin
        res_q  <= bus.alu_out;
        zero_q <= bus.alu_zero;
      end
    end
`ifdef ALU_ARBITER_OPCHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else if (state == EXEC) err_q <= !op_legal(op_q);
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif
endmodule
